cisr_wb_arbiter: RTL

CISR_WB_ARBITER -- requirements
Module: cisr_wb_arbiter

---
 rtl/cisr_wb_arbiter_if.sv | 23 ++
 rtl/cisr_wb_arbiter.sv | 87 ++++++++
 2 files changed

// File: rtl/cisr_wb_arbiter_if.sv
// cisr_wb_arbiter_if: channel-result and result-memory signals of the write-back arbiter
interface cisr_wb_arbiter_if #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [CHANNELS-1:0]        done_valid;
  logic [CHANNELS*ADDR_W-1:0] done_row;
  logic [CHANNELS*DATA_W-1:0] done_sum;
  logic [CHANNELS-1:0]        done_ready;
  logic                       mem_write;
  logic [ADDR_W-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_data;
  logic                       mem_ready;
  modport master (
    output done_valid, done_row, done_sum, mem_ready,
    input  done_ready, mem_write, mem_addr, mem_data
  );
  modport slave (
    input  done_valid, done_row, done_sum, mem_ready,
    output done_ready, mem_write, mem_addr, mem_data
  );
endinterface

// File: rtl/cisr_wb_arbiter.sv
// cisr_wb_arbiter: round-robin write-back of per-channel row sums into result memory
module cisr_wb_arbiter #(
  parameter int CHANNELS = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W:0]     num_rows,
  cisr_wb_arbiter_if.slave    bus,
  output logic                busy,
  output logic                job_done
);
  localparam int PW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [CHANNELS-1:0] ent_v;
  logic [ADDR_W-1:0] ent_row [CHANNELS];
  logic [DATA_W-1:0] ent_sum [CHANNELS];
  logic [PW-1:0] rr_ptr, gnt_idx, scan;
  logic [ADDR_W:0] rows, cnt, cnt_inc;
  logic gnt_any, gnt, hs, free, last;
  assign hs = bus.mem_write && bus.mem_ready;
  assign free = !bus.mem_write || bus.mem_ready;
  assign cnt_inc = cnt + (ADDR_W+1)'(1);
  assign last = hs && cnt_inc == rows;
  // no new grant on the closing handshake, so DONE is entered with the output idle
  assign gnt = gnt_any && free && state == RUN && !last;
  assign busy = state == RUN;
  assign job_done = state == DONE;
  assign bus.done_ready = state == RUN ? ~ent_v : '0;
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      scan = PW'((int'(rr_ptr) + k) % CHANNELS);
      if (!gnt_any && ent_v[scan]) begin
        gnt_any = 1'b1;
        gnt_idx = scan;
      end
    end
  end
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start) state_nxt = |num_rows ? RUN : DONE;
    if (state == RUN && last) state_nxt = DONE;
    if (state == DONE) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ent_v <= '0;
      rr_ptr <= PW'(CHANNELS - 1);
      cnt <= '0;
      rows <= '0;
      bus.mem_write <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        rows <= num_rows;
        cnt <= '0;
      end
      if (hs) cnt <= cnt_inc;
      if (gnt) begin
        bus.mem_write <= 1'b1;
        bus.mem_addr <= ent_row[gnt_idx];
        bus.mem_data <= ent_sum[gnt_idx];
        rr_ptr <= gnt_idx;
      end else if (hs) begin
        bus.mem_write <= 1'b0;
      end
      for (int i = 0; i < CHANNELS; i++)
        if (state != RUN || (gnt && gnt_idx == PW'(i))) ent_v[i] <= 1'b0;
        else if (bus.done_valid[i] && bus.done_ready[i]) ent_v[i] <= 1'b1;
    end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < CHANNELS; i++)
      if (bus.done_valid[i] && bus.done_ready[i]) begin
        ent_row[i] <= bus.done_row[i*ADDR_W +: ADDR_W];
        ent_sum[i] <= bus.done_sum[i*DATA_W +: DATA_W];
      end
endmodule
